dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 41 ++++
 rtl/arb_rd_tag_pipe.sv | 55 +++++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the dmem arbiter: default widths, requester port
// identifiers, the arbiter FSM encoding and the wait-counter update helper.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_MAX_WAIT = 4;

    // Wide enough for MAX_WAIT-1 up to 14.
    localparam int WAIT_W = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Saturating count of consecutive denied cycles; clears when not waiting.
    function automatic logic [WAIT_W-1:0] wait_next(
        input logic [WAIT_W-1:0] cur,
        input logic              waiting,
        input logic [WAIT_W-1:0] limit
    );
        logic [WAIT_W-1:0] nxt;
        if (!waiting) begin
            nxt = {WAIT_W{1'b0}};
        end else if (cur == limit) begin
            nxt = cur;
        end else begin
            nxt = cur + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// arb_rd_tag_pipe
// RD_LAT-stage shift register of {valid, port_id} tags that tracks granted
// reads until the dmem returns their data.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   push_valid, push_id tag entering the pipe this cycle
//   tail_valid, tail_id tag whose read data is on mem_q this cycle
// ---------------------------------------------------------------------------
module arb_rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic push_valid,
    input  logic push_id,
    output logic tail_valid,
    output logic tail_id
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] valid_d;
    logic [RD_LAT-1:0] id_q;
    logic [RD_LAT-1:0] id_d;

    // Next-stage values: shift every tag one stage toward the tail.
    always_comb begin
        valid_d    = valid_q;
        id_d       = id_q;
        valid_d[0] = push_valid;
        id_d[0]    = push_id;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    // Tag storage; reset drops every in-flight read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= {RD_LAT{1'b0}};
            id_q    <= {RD_LAT{1'b0}};
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    // Tail of the pipe lines up with the data on mem_q.
    always_comb begin
        tail_valid = valid_q[RD_LAT-1];
        tail_id    = id_q[RD_LAT-1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port dmem between the processor (port 0) and the
// debug/loader (port 1). One access is granted per cycle: round-robin on
// contention, port 1 may lock ownership for bursts, and a starvation bound
// forces port 0 through after MAX_WAIT-1 consecutive denied cycles.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   pN_req/wren/address/data     access request from port N
//   pN_gnt                       combinational accept for port N
//   pN_rvalid, pN_q              read return for port N (0 when not valid)
//   p1_lock                      port 1 keeps ownership after its grant
//   mem_address/data/wren, mem_q dmem interface
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_q,
    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_q,
    input  logic              p1_lock,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [WAIT_W-1:0] wait0_q, wait0_d;
    logic [WAIT_W-1:0] wait1_q, wait1_d;
    logic              win_valid;
    logic              win_id;
    logic              rd_push;
    logic              tail_valid;
    logic              tail_id;

    // Winner selection, highest priority first.
    always_comb begin
        win_valid = 1'b0;
        win_id    = PORT_CPU;
        if (p0_req && (wait0_q == WAIT_LIMIT)) begin
            win_valid = 1'b1;
            win_id    = PORT_CPU;
        end else if (state_q == ST_LOCKED) begin
            if (p1_req) begin
                win_valid = 1'b1;
                win_id    = PORT_DBG;
            end else if (p0_req) begin
                win_valid = 1'b1;
                win_id    = PORT_CPU;
            end else begin
                win_valid = 1'b0;
                win_id    = PORT_CPU;
            end
        end else if (p0_req && p1_req) begin
            win_valid = 1'b1;
            // A saturated port-1 wait implies port 0 won last, so this
            // agrees with plain round-robin; it only makes the bound explicit.
            win_id    = (wait1_q == WAIT_LIMIT) ? PORT_DBG : ~last_q;
        end else if (p0_req) begin
            win_valid = 1'b1;
            win_id    = PORT_CPU;
        end else if (p1_req) begin
            win_valid = 1'b1;
            win_id    = PORT_DBG;
        end else begin
            win_valid = 1'b0;
            win_id    = PORT_CPU;
        end
    end

    // Grants and the dmem mux; idle cycles drive zeros onto the dmem.
    always_comb begin
        p0_gnt      = win_valid && (win_id == PORT_CPU);
        p1_gnt      = win_valid && (win_id == PORT_DBG);
        mem_address = {ADDR_W{1'b0}};
        mem_data    = {DATA_W{1'b0}};
        mem_wren    = 1'b0;
        if (p1_gnt) begin
            mem_address = p1_address;
            mem_data    = p1_data;
            mem_wren    = p1_wren;
        end else if (p0_gnt) begin
            mem_address = p0_address;
            mem_data    = p0_data;
            mem_wren    = p0_wren;
        end else begin
            mem_address = {ADDR_W{1'b0}};
            mem_data    = {DATA_W{1'b0}};
            mem_wren    = 1'b0;
        end
        rd_push = win_valid && !mem_wren;
    end

    // Next-state for round-robin pointer, wait counters and lock FSM.
    always_comb begin
        last_d  = win_valid ? win_id : last_q;
        wait0_d = wait_next(wait0_q, p0_req && !p0_gnt, WAIT_LIMIT);
        wait1_d = wait_next(wait1_q, p1_req && !p1_gnt, WAIT_LIMIT);
        case (state_q)
            ST_IDLE:   state_d = (p1_gnt && p1_lock) ? ST_LOCKED : ST_IDLE;
            // A starvation grant to port 0 does not release the lock.
            ST_LOCKED: state_d = p1_lock ? ST_LOCKED : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_DBG;
            wait0_q <= {WAIT_W{1'b0}};
            wait1_q <= {WAIT_W{1'b0}};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
        end
    end

    arb_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .push_valid (rd_push),
        .push_id    (win_id),
        .tail_valid (tail_valid),
        .tail_id    (tail_id)
    );

    // Steer returning read data to the tagged port; the other port reads 0.
    always_comb begin
        p0_rvalid = tail_valid && (tail_id == PORT_CPU);
        p1_rvalid = tail_valid && (tail_id == PORT_DBG);
        p0_q      = p0_rvalid ? mem_q : {DATA_W{1'b0}};
        p1_q      = p1_rvalid ? mem_q : {DATA_W{1'b0}};
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              p0_req = 1'b0, p0_wren = 1'b0;
    logic [ADDR_W-1:0] p0_address = '0;
    logic [DATA_W-1:0] p0_data = '0;
    logic              p0_gnt, p0_rvalid;
    logic [DATA_W-1:0] p0_q;
    logic              p1_req = 1'b0, p1_wren = 1'b0, p1_lock = 1'b0;
    logic [ADDR_W-1:0] p1_address = '0;
    logic [DATA_W-1:0] p1_data = '0;
    logic              p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p1_q;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_wren(p0_wren), .p0_address(p0_address), .p0_data(p0_data),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_q(p0_q),
        .p1_req(p1_req), .p1_wren(p1_wren), .p1_address(p1_address), .p1_data(p1_data),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_q(p1_q),
        .p1_lock(p1_lock),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // dmem syncram with RD_LAT cycles of read latency
    logic [DATA_W-1:0] mem_arr [0:DEPTH-1];
    logic [DATA_W-1:0] q_pipe  [0:RD_LAT-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_arr[i] <= '0;
        for (int i = 0; i < RD_LAT; i++) q_pipe[i] <= '0;
    end
    always @(posedge clock) begin
        if (mem_wren) mem_arr[mem_address] <= mem_data;
        q_pipe[0] <= mem_arr[mem_address];
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q = q_pipe[RD_LAT-1];

    // counters, scoreboard, reference model
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int m_locked, m_last, m_wait0, m_wait1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_winner(input bit r0, input bit r1);
        if (r0 && m_wait0 == MAX_WAIT - 1) return 0;
        if (m_locked != 0) begin
            if (r1) return 1;
            if (r0) return 0;
            return -1;
        end
        if (r0 && r1) return 1 - m_last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_last = 1; m_wait0 = 0; m_wait1 = 0;
    endtask

    // One arbitration cycle: drive at negedge, check grant/mux, update model.
    task automatic step(input bit r0, input bit w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input bit r1, input bit w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input bit lk, input int want, output int win);
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        bit                ew;
        int                dut_win;
        @(negedge clock);
        p0_req = r0; p0_wren = w0; p0_address = a0; p0_data = d0;
        p1_req = r1; p1_wren = w1; p1_address = a1; p1_data = d1;
        p1_lock = lk;
        #1;
        win = model_winner(r0, r1);
        dut_win = p0_gnt ? 0 : (p1_gnt ? 1 : -1);
        if (want != -2) chk("directed_winner", 64'(dut_win), 64'(want));
        chk("p0_gnt", p0_gnt, win == 0);
        chk("p1_gnt", p1_gnt, win == 1);
        ea = (win == 0) ? a0 : ((win == 1) ? a1 : '0);
        ed = (win == 0) ? d0 : d1;
        ew = (win == 0 && w0) || (win == 1 && w1);
        chk("mem_address", mem_address, ea);
        chk("mem_wren", mem_wren, ew);
        if (ew) chk("mem_data", mem_data, ed);
        if (win >= 0) begin
            if (ew) ref_mem[ea] = ed;
            else    sb.push_back('{port: win, data: ref_mem[ea], due: cyc + RD_LAT});
            m_last = win;
        end
        m_wait0 = (r0 && win != 0) ? ((m_wait0 < MAX_WAIT - 1) ? m_wait0 + 1 : m_wait0) : 0;
        m_wait1 = (r1 && win != 1) ? ((m_wait1 < MAX_WAIT - 1) ? m_wait1 + 1 : m_wait1) : 0;
        if (m_locked == 0 && win == 1 && lk) m_locked = 1;
        else if (m_locked != 0 && !lk)       m_locked = 0;
    endtask

    task automatic idle(input int n);
        int w;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0, -2, w);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
        sb.delete();
        #1;
        chk("rst_p0_gnt", p0_gnt, 1'b0);
        chk("rst_p1_gnt", p1_gnt, 1'b0);
        chk("rst_mem_wren", mem_wren, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_p0_rvalid", p0_rvalid, 1'b0);
        chk("rst_p1_rvalid", p1_rvalid, 1'b0);
        chk("rst_p0_q", p0_q, '0);
        chk("rst_p1_q", p1_q, '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: pop the scoreboard whenever the DUT returns read data.
    always @(posedge clock) begin
        exp_t e;
        #1;
        chk("rvalid_onehot", p0_rvalid & p1_rvalid, 1'b0);
        if (p0_rvalid || p1_rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid actual p0=%0b p1=%0b required none", p0_rvalid, p1_rvalid);
            end else begin
                e = sb.pop_front();
                chk("rvalid_port", p1_rvalid, e.port == 1);
                chk("rvalid_data", (e.port == 1) ? p1_q : p0_q, e.data);
                chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                chk("other_q_zero", (e.port == 1) ? p0_q : p1_q, '0);
            end
        end else begin
            chk("q_zero_idle", p0_q | p1_q, '0);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_rvalid actual none required port%0d data=%0h", sb[0].port, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lock_seq [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        int drop_seq [4] = '{1, 0, 1, 0};
        bit pend0, pend1, rw0, rw1, lk;
        logic [ADDR_W-1:0] ra0, ra1;
        logic [DATA_W-1:0] rd0, rd1;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        model_reset();
        do_reset();

        // preload 0xDEADBEEF at 5 via port 1, read back via port 0
        step(0, 0, '0, '0, 1, 1, 12'd5, 32'hDEADBEEF, 0, 1, w);
        step(1, 0, 12'd5, '0, 0, 0, '0, '0, 0, 0, w);
        // top-of-memory write then read, and no aliasing at 0x000
        step(0, 0, '0, '0, 1, 1, 12'hFFF, 32'h12345678, 0, 1, w);
        step(0, 0, '0, '0, 1, 0, 12'hFFF, '0, 0, 1, w);
        step(0, 0, '0, '0, 1, 0, 12'h000, '0, 0, 1, w);
        idle(RD_LAT + 1);

        // reset one cycle after a granted read drops the read
        step(1, 0, 12'd5, '0, 0, 0, '0, '0, 0, 0, w);
        do_reset();
        // tie after reset: p0 first, then alternation
        for (int i = 0; i < 6; i++)
            step(1, 0, 12'h010 + 12'(i), '0, 1, 0, 12'h020 + 12'(i), '0, 0, i % 2, w);
        idle(RD_LAT + 1);

        // lock burst with starvation relief, then release
        step(0, 0, '0, '0, 1, 0, 12'h030, '0, 1, 1, w);
        for (int i = 0; i < 8; i++)
            step(1, 0, 12'h040, '0, 1, 0, 12'h050, '0, 1, lock_seq[i], w);
        for (int i = 0; i < 4; i++)
            step(1, 0, 12'h041, '0, 1, 0, 12'h051, '0, 0, drop_seq[i], w);
        idle(RD_LAT + 1);

        // preload 0..7, then 8 back-to-back port 0 reads
        for (int i = 0; i < 8; i++)
            step(0, 0, '0, '0, 1, 1, 12'(i), 32'hA5000000 + 32'(i * 17), 0, 1, w);
        for (int i = 0; i < 8; i++)
            step(1, 0, 12'(i), '0, 0, 0, '0, '0, 0, 0, w);
        idle(RD_LAT + 1);

        // randomized traffic, requests held until granted
        pend0 = 0; pend1 = 0; rw0 = 0; rw1 = 0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!pend0) pend0 = ($urandom_range(0, 99) < 60);
            if (!pend1) pend1 = ($urandom_range(0, 99) < 60);
            if (pend0) begin
                rw0 = 1'($urandom_range(0, 1));
                ra0 = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
                rd0 = $urandom;
            end
            if (pend1) begin
                rw1 = 1'($urandom_range(0, 1));
                ra1 = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
                rd1 = $urandom;
            end
            lk = ($urandom_range(0, 99) < 35);
            step(pend0, rw0, ra0, rd0, pend1, rw1, ra1, rd1, lk, -2, w);
            if (w == 0) pend0 = 0;
            if (w == 1) pend1 = 0;
        end
        idle(RD_LAT + 2);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
